// File: rtl/mem_read_unit.sv
`timescale 1ns/1ps
// Purpose : memory-read sequencer loading the MDR; rejects misaligned loads.
// Latency : accept at edge k, memory sampled at edge k+WAIT_CYCLES, rd_done the cycle after.
// Backpr. : one read in flight; rd_req ignored (not queued) while busy.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   rd_req, rd_addr       - read request and byte address (request sampled in IDLE only)
//   load_size_control     - bit1=1 byte, else bit0=1 half, 00 word
//   mem_data_in           - word returned by memory
//   mem_addr, mem_rd      - registered address and read strobe to memory
//   mdr_out               - memory data register, feeds the load-size extraction stage
//   busy                  - read in flight (same as mem_rd)
//   rd_done, align_err    - one-cycle registered completion / rejection pulses
module mem_read_unit #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic [1:0]  load_size_control,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] mdr_out,
    output logic        busy,
    output logic        rd_done,
    output logic        align_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Counter starts at WAIT_CYCLES-1 so the capture edge is the WAIT_CYCLES-th edge after accept.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mdr_q, mdr_d;
    logic        rd_done_q, rd_done_d;
    logic        align_err_q, align_err_d;
    logic        misaligned;

    // Size decode gives bit1 priority, so 11 is treated as a byte load.
    always_comb begin
        misaligned = 1'b0;
        if (load_size_control[1]) begin
            misaligned = 1'b0;
        end else if (load_size_control[0]) begin
            misaligned = rd_addr[0];
        end else begin
            misaligned = |rd_addr[1:0];
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            mem_addr_q  <= 32'd0;
            mdr_q       <= 32'd0;
            rd_done_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mdr_q       <= mdr_d;
            rd_done_q   <= rd_done_d;
            align_err_q <= align_err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mdr_d       = mdr_q;
        rd_done_d   = 1'b0;
        align_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    if (misaligned) begin
                        // Rejected: no memory access, address and MDR untouched.
                        align_err_d = 1'b1;
                    end else begin
                        mem_addr_d = rd_addr;
                        cnt_d      = CNT_INIT;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mdr_d     = mem_data_in;
                    rd_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: strobe decoded straight from the state register.
    always_comb begin
        mem_rd = (state_q == S_WAIT);
        busy   = (state_q == S_WAIT);
    end

    assign mem_addr  = mem_addr_q;
    assign mdr_out   = mdr_q;
    assign rd_done   = rd_done_q;
    assign align_err = align_err_q;

endmodule
